// File: rtl/pcie_msg_sender.sv
// Reads a message from SRAM and sends it as AXI4 INCR write bursts, one per fragment:
// a header beat followed by up to MAX_FRAG_BEATS payload beats from a 2-entry prefetch buffer.
module pcie_msg_sender #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 10,
  parameter int MAX_FRAG_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_sram_addr,
  input  logic [11:0]             cmd_len,
  input  logic [3:0]              cmd_tag,
  input  logic [63:0]             cmd_dest_addr,
  output logic                    sram_ren,
  output logic [ADDR_WIDTH-1:0]   sram_raddr,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [63:0]             axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  input  logic                    axi_bvalid,
  input  logic [1:0]              axi_bresp,
  output logic                    axi_bready,
  output logic                    done,
  output logic                    err
);
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_WAIT_B} state_e;
  localparam logic [11:0] MAX_L = 12'(MAX_FRAG_BEATS);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [11:0]             len_q, len_d, remaining_q, remaining_d;
  logic [3:0]              tag_q, tag_d;
  logic [63:0]             dest_q, dest_d;
  logic [7:0]              frag_idx_q, frag_idx_d, rd_cnt_q, rd_cnt_d, beat_q, beat_d;
  logic                    done_q, done_d, err_q, err_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    inflight_q, inflight_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic [7:0]              frag_len_c;
  logic [DATA_WIDTH-1:0]   header_c;
  logic                    pop_c, ren_c;
  logic [2:0]              occ_c;

  assign frag_len_c = (remaining_q < MAX_L) ? remaining_q[7:0] : MAX_L[7:0];
  // A payload pop this cycle frees a slot, which keeps reads streaming at one per cycle.
  assign pop_c = (state_q == S_W) && (beat_q != 8'd0) && (cnt_q != 2'd0) && axi_wready;
  assign occ_c = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign ren_c = ((state_q == S_AW) || (state_q == S_W)) && (rd_cnt_q < frag_len_c) &&
                 (occ_c < (3'd2 + {2'b00, pop_c}));

  always_comb begin
    header_c        = '0;
    header_c[3:0]   = tag_q;
    header_c[11:4]  = frag_idx_q;
    header_c[12]    = (remaining_q == {4'b0000, frag_len_c});
    header_c[27:16] = {4'b0000, frag_len_c};
    header_c[39:28] = len_q;
  end

  assign sram_ren    = ren_c;
  assign sram_raddr  = addr_q;
  assign axi_awaddr  = dest_q;
  assign axi_awlen   = frag_len_c;
  assign axi_awsize  = 3'b101;
  assign axi_awburst = 2'b01;
  assign axi_wstrb   = '1;
  assign done        = done_q;
  assign err         = err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q + {{(ADDR_WIDTH-1){1'b0}}, ren_c};
    len_d       = len_q;
    tag_d       = tag_q;
    dest_d      = dest_q;
    frag_idx_d  = frag_idx_q;
    remaining_d = remaining_q;
    rd_cnt_d    = rd_cnt_q + {7'd0, ren_c};
    beat_d      = beat_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q + {1'b0, inflight_q} - {1'b0, pop_c};
    inflight_d  = ren_c;
    wr_ptr_d    = wr_ptr_q ^ inflight_q;
    rd_ptr_d    = rd_ptr_q ^ pop_c;
    cmd_ready   = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_wdata   = '0;
    axi_wlast   = 1'b0;
    axi_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d      = cmd_sram_addr;
          len_d       = cmd_len;
          tag_d       = cmd_tag;
          dest_d      = cmd_dest_addr;
          frag_idx_d  = 8'd0;
          remaining_d = cmd_len;
          rd_cnt_d    = 8'd0;
          if (cmd_len == 12'd0) done_d = 1'b1;
          else                  state_d = S_AW;
        end
      end
      S_AW: begin
        axi_awvalid = 1'b1;
        if (axi_awready) begin
          state_d = S_W;
          beat_d  = 8'd0;
        end
      end
      S_W: begin
        axi_wvalid = (beat_q == 8'd0) || (cnt_q != 2'd0);
        axi_wdata  = (beat_q == 8'd0) ? header_c : buf_q[rd_ptr_q];
        axi_wlast  = (beat_q == frag_len_c);
        if (axi_wvalid && axi_wready) begin
          beat_d = beat_q + 8'd1;
          if (axi_wlast) state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          if (axi_bresp == 2'b00) begin
            remaining_d = remaining_q - {4'b0000, frag_len_c};
            frag_idx_d  = frag_idx_q + 8'd1;
            rd_cnt_d    = 8'd0;
            if (remaining_q == {4'b0000, frag_len_c}) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_AW;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      tag_q       <= '0;
      dest_q      <= '0;
      frag_idx_q  <= '0;
      remaining_q <= '0;
      rd_cnt_q    <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      tag_q       <= tag_d;
      dest_q      <= dest_d;
      frag_idx_q  <= frag_idx_d;
      remaining_q <= remaining_d;
      rd_cnt_q    <= rd_cnt_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // SRAM data lands one cycle after the read; capture it into the buffer slot.
  always_ff @(posedge clk) begin
    if (inflight_q) buf_q[wr_ptr_q] <= sram_rdata;
  end
endmodule
